// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Consumes the EX/MEM latch, runs
// single-outstanding loads/stores on the req/ack data bus, stalls upstream
// while a transfer is in flight, and produces the MEM/WB latch.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_mem_valid,
   input  logic [31:0] ex_mem_ir,
   input  logic [31:0] ex_mem_cond,
   input  logic [31:0] ex_mem_alu,
   input  logic [31:0] ex_mem_b,
   output logic        stall,
   output logic        branch_taken,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_wb_valid,
   output logic [31:0] mem_wb_ir,
   output logic [31:0] mem_wb_alu,
   output logic [31:0] mem_wb_lmd,
   output logic        mem_wb_fault
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam int         CW        = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST   = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE, REQ} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    funct3;
   logic          is_load, is_store, is_mem, misaligned;
   logic [3:0]    be_fmt;
   logic [31:0]   wdata_fmt, lane_data, load_data, lmd_nx;
   logic          launch, retire, fault_nx, cnt_inc, req_drop;
   logic          unused_bits;

   assign unused_bits  = ^{ex_mem_cond[31:1], ex_mem_ir[31:15], ex_mem_ir[11:7], lane_data[31:16]};
   assign branch_taken = ex_mem_valid & ex_mem_cond[0] & (ex_mem_ir[6:0] == OP_BRANCH);

   // Decode, alignment check and store-lane formatting of the EX/MEM instruction
   always_comb begin
      funct3     = ex_mem_ir[14:12];
      is_load    = (ex_mem_ir[6:0] == OP_LOAD);
      is_store   = (ex_mem_ir[6:0] == OP_STORE);
      is_mem     = is_load | is_store;
      misaligned = 1'b0;
      be_fmt     = '0;
      wdata_fmt  = '0;
      case (funct3)
         3'b000: begin
            be_fmt    = 4'b0001 << ex_mem_alu[1:0];
            wdata_fmt = {4{ex_mem_b[7:0]}};
         end
         3'b001: begin
            misaligned = ex_mem_alu[0];
            be_fmt     = 4'b0011 << ex_mem_alu[1:0];
            wdata_fmt  = {2{ex_mem_b[15:0]}};
         end
         3'b010: begin
            misaligned = |ex_mem_alu[1:0];
            be_fmt     = 4'hF;
            wdata_fmt  = ex_mem_b;
         end
         3'b100:  misaligned = is_store;
         3'b101:  misaligned = is_store | ex_mem_alu[0];
         default: misaligned = 1'b1;
      endcase
      if (!is_store) begin
         be_fmt    = '0;
         wdata_fmt = '0;
      end
   end

   // Load data lane selection and sign/zero extension
   always_comb begin
      lane_data = dmem_rdata >> {ex_mem_alu[1:0], 3'b000};
      case (funct3)
         3'b000:  load_data = {{24{lane_data[7]}}, lane_data[7:0]};
         3'b001:  load_data = {{16{lane_data[15]}}, lane_data[15:0]};
         3'b010:  load_data = dmem_rdata;
         3'b100:  load_data = {24'b0, lane_data[7:0]};
         3'b101:  load_data = {16'b0, lane_data[15:0]};
         default: load_data = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // FSM next state, stall and datapath control
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      launch   = 1'b0;
      retire   = 1'b0;
      fault_nx = 1'b0;
      lmd_nx   = '0;
      cnt_inc  = 1'b0;
      req_drop = 1'b0;
      case (state)
         IDLE: begin
            if (ex_mem_valid) begin
               if (is_mem && !misaligned) begin
                  stall    = 1'b1;
                  launch   = 1'b1;
                  state_nx = REQ;
               end else begin
                  retire   = 1'b1;
                  fault_nx = is_mem;
               end
            end
         end
         REQ: begin
            // ack wins over timeout when both land on the last REQ cycle
            if (dmem_ack) begin
               retire   = 1'b1;
               lmd_nx   = is_load ? load_data : '0;
               req_drop = 1'b1;
               state_nx = IDLE;
            end else if (cnt == LAST) begin
               retire   = 1'b1;
               fault_nx = 1'b1;
               req_drop = 1'b1;
               state_nx = IDLE;
            end else begin
               stall   = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bus request registers, wait counter and MEM/WB latch
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_be      <= '0;
         mem_wb_valid <= 1'b0;
         mem_wb_ir    <= '0;
         mem_wb_alu   <= '0;
         mem_wb_lmd   <= '0;
         mem_wb_fault <= 1'b0;
      end else begin
         if (launch) begin
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= ex_mem_alu;
            dmem_wdata <= wdata_fmt;
            dmem_be    <= be_fmt;
         end
         if (cnt_inc)  cnt      <= cnt + CW'(1);
         if (req_drop) dmem_req <= 1'b0;
         mem_wb_valid <= retire;
         if (retire) begin
            mem_wb_ir    <= ex_mem_ir;
            mem_wb_alu   <= ex_mem_alu;
            mem_wb_lmd   <= lmd_nx;
            mem_wb_fault <= fault_nx;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, reset-abort sequence and randomized
// instructions checked against a transaction-level model of the stage.
module tb_mem_stage;

   localparam int TO    = 4;
   localparam int NEVER = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_mem_valid;
   logic [31:0] ex_mem_ir, ex_mem_cond, ex_mem_alu, ex_mem_b;
   logic        stall, branch_taken;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        mem_wb_valid;
   logic [31:0] mem_wb_ir, mem_wb_alu, mem_wb_lmd;
   logic        mem_wb_fault;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir), .ex_mem_cond(ex_mem_cond),
      .ex_mem_alu(ex_mem_alu), .ex_mem_b(ex_mem_b),
      .stall(stall), .branch_taken(branch_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_wb_valid(mem_wb_valid), .mem_wb_ir(mem_wb_ir), .mem_wb_alu(mem_wb_alu),
      .mem_wb_lmd(mem_wb_lmd), .mem_wb_fault(mem_wb_fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // observations of the last instruction run through the stage
   logic        r_req, r_we;
   logic [3:0]  r_be;
   logic [31:0] r_wdata, r_addr;
   int          r_stall, r_reqcyc;

   typedef struct {
      logic [31:0] ir, alu, b, rdata, cond;
      int          waits;
      logic        req, we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          stall, reqcyc;
      logic [31:0] lmd;
      logic        fault;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Presents one instruction, plays the memory side (ack after 'waits' REQ
   // cycles), holds it while stall is high and returns just after retirement.
   task automatic run_instr(input logic [31:0] ir, alu, b, rdata, cond, input int waits);
      logic s;
      logic done;
      ex_mem_valid = 1'b1;
      ex_mem_ir    = ir;
      ex_mem_alu   = alu;
      ex_mem_b     = b;
      ex_mem_cond  = cond;
      check("req_gap", {31'b0, dmem_req}, 32'd0);
      r_req = 1'b0; r_we = 1'b0; r_be = '0; r_wdata = '0; r_addr = '0;
      r_stall = 0; r_reqcyc = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         dmem_ack   = 1'b0;
         dmem_rdata = $urandom;
         if (dmem_req) begin
            r_req = 1'b1; r_we = dmem_we; r_be = dmem_be;
            r_wdata = dmem_wdata; r_addr = dmem_addr;
            r_reqcyc++;
            if (r_reqcyc == waits + 1) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
         end
         @(negedge clk);
         if (cyc == 0)
            check("branch_taken", {31'b0, branch_taken},
                  {31'b0, (ir[6:0] == 7'b1100011) && cond[0]});
         s = stall;
         if (s) r_stall++;
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
         if (!s) done = 1'b1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL retire_bound: instruction 0x%08h never retired within 40 cycles", ir);
      end
      ex_mem_valid = 1'b0;
   endtask

   task automatic verify(input logic [31:0] ir, alu, input logic exp_req, exp_we,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input int exp_stall, exp_reqcyc,
                         input logic [31:0] exp_lmd, input logic exp_fault);
      check("bus_req", {31'b0, r_req}, {31'b0, exp_req});
      if (exp_req) begin
         check("bus_we",   {31'b0, r_we}, {31'b0, exp_we});
         check("bus_addr", r_addr, alu);
         check("bus_be",   {28'b0, r_be}, {28'b0, exp_be});
         if (exp_we) check("bus_wdata", r_wdata, exp_wdata);
      end
      check("stall_cycles", 32'(r_stall), 32'(exp_stall));
      check("req_cycles",   32'(r_reqcyc), 32'(exp_reqcyc));
      check("wb_valid", {31'b0, mem_wb_valid}, 32'd1);
      check("wb_ir",    mem_wb_ir, ir);
      check("wb_alu",   mem_wb_alu, alu);
      check("wb_lmd",   mem_wb_lmd, exp_lmd);
      check("wb_fault", {31'b0, mem_wb_fault}, {31'b0, exp_fault});
   endtask

   // Transaction-level reference: access size, alignment by modulo, byte
   // lanes by loop, extension by mask arithmetic.
   task automatic model(input logic [31:0] ir, alu, b, rdata, input int waits,
                        output logic req, we, output logic [3:0] be,
                        output logic [31:0] wdata, output int st, rc,
                        output logic [31:0] lmd, output logic fault);
      logic        ld, sd;
      int          size, off;
      logic [31:0] mask, v;
      logic [2:0]  f3;
      f3 = ir[14:12];
      ld = (ir[6:0] == 7'b0000011);
      sd = (ir[6:0] == 7'b0100011);
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      if (sd && f3 > 3'd2) size = 0;
      req = 0; we = 0; be = '0; wdata = '0; st = 0; rc = 0; lmd = '0; fault = 0;
      if (!(ld || sd)) return;
      if (size == 0 || (alu % size) != 0) begin
         fault = 1;
         return;
      end
      req = 1;
      we  = sd;
      off = int'(alu % 4);
      if (sd) begin
         for (int i = 0; i < 4; i++) begin
            v = b >> (8 * (i % size));
            wdata[8*i +: 8] = v[7:0];
            be[i] = (i >= off) && (i < off + size);
         end
      end
      if (waits + 1 <= TO) begin
         st = waits + 1;
         rc = waits + 1;
         if (ld) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            v    = (rdata >> (8 * off)) & mask;
            if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
            lmd = v;
         end
      end else begin
         st    = TO;
         rc    = TO;
         fault = 1;
      end
   endtask

   initial begin
      logic        e_req, e_we, e_fault;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_lmd, ir, alu, b, rd, cnd, last_lmd, tmp;
      int          e_st, e_rc, w, op;
      logic [6:0]  ops [4];

      vecs[0]  = '{32'h00000033, 32'h00001234, 32'h0, 32'h0, 32'h0, 0,     1'b0, 1'b0, 4'b0000, 32'h0,        0, 0, 32'h0,        1'b0};
      vecs[1]  = '{32'h00000003, 32'h00000103, 32'h0, 32'h80FFFFFF, 32'h0, 0, 1'b1, 1'b0, 4'b0000, 32'h0,  1, 1, 32'hFFFFFF80, 1'b0};
      vecs[2]  = '{32'h00004003, 32'h00000103, 32'h0, 32'h80FFFFFF, 32'h0, 0, 1'b1, 1'b0, 4'b0000, 32'h0,  1, 1, 32'h00000080, 1'b0};
      vecs[3]  = '{32'h00001023, 32'h00000202, 32'hAAAABEEF, 32'h0, 32'h0, 3, 1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF, 4, 4, 32'h0, 1'b0};
      vecs[4]  = '{32'h00002003, 32'h00000301, 32'h0, 32'h0, 32'h0, 0,     1'b0, 1'b0, 4'b0000, 32'h0,        0, 0, 32'h0,        1'b1};
      vecs[5]  = '{32'h00002003, 32'h00000400, 32'h0, 32'h0, 32'h0, NEVER, 1'b1, 1'b0, 4'b0000, 32'h0,        4, 4, 32'h0,        1'b1};
      vecs[6]  = '{32'h00000023, 32'h00000101, 32'h12345678, 32'h0, 32'h0, 1, 1'b1, 1'b1, 4'b0010, 32'h78787878, 2, 2, 32'h0, 1'b0};
      vecs[7]  = '{32'h00001003, 32'h00000102, 32'h0, 32'h80011234, 32'h0, 0, 1'b1, 1'b0, 4'b0000, 32'h0,  1, 1, 32'hFFFF8001, 1'b0};
      vecs[8]  = '{32'h00005003, 32'h00000102, 32'h0, 32'h80011234, 32'h0, 0, 1'b1, 1'b0, 4'b0000, 32'h0,  1, 1, 32'h00008001, 1'b0};
      vecs[9]  = '{32'h00002023, 32'h00000020, 32'hDEADBEEF, 32'h0, 32'h0, 0, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF, 1, 1, 32'h0, 1'b0};
      vecs[10] = '{32'h00004023, 32'h00000000, 32'h0, 32'h0, 32'h0, 0,     1'b0, 1'b0, 4'b0000, 32'h0,        0, 0, 32'h0,        1'b1};
      vecs[11] = '{32'h00002003, 32'h00000044, 32'h0, 32'hCAFEF00D, 32'h0, 2, 1'b1, 1'b0, 4'b0000, 32'h0,  3, 3, 32'hCAFEF00D, 1'b0};
      vecs[12] = '{32'h00000063, 32'h00000088, 32'h0, 32'h0, 32'h1, 0,     1'b0, 1'b0, 4'b0000, 32'h0,        0, 0, 32'h0,        1'b0};
      vecs[13] = '{32'h00002003, 32'h00000008, 32'h0, 32'h11223344, 32'h0, 3, 1'b1, 1'b0, 4'b0000, 32'h0,  4, 4, 32'h11223344, 1'b0};

      reset = 1'b1; ex_mem_valid = 1'b0; ex_mem_ir = '0; ex_mem_cond = '0;
      ex_mem_alu = '0; ex_mem_b = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_req",   {31'b0, dmem_req}, 32'd0);
      check("rst_we",    {31'b0, dmem_we}, 32'd0);
      check("rst_addr",  dmem_addr, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_be",    {28'b0, dmem_be}, 32'd0);
      check("rst_valid", {31'b0, mem_wb_valid}, 32'd0);
      check("rst_ir",    mem_wb_ir, 32'd0);
      check("rst_lmd",   mem_wb_lmd, 32'd0);
      check("rst_fault", {31'b0, mem_wb_fault}, 32'd0);

      // directed vectors, back to back
      for (int i = 0; i < 14; i++) begin
         run_instr(vecs[i].ir, vecs[i].alu, vecs[i].b, vecs[i].rdata, vecs[i].cond, vecs[i].waits);
         verify(vecs[i].ir, vecs[i].alu, vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].wdata,
                vecs[i].stall, vecs[i].reqcyc, vecs[i].lmd, vecs[i].fault);
      end
      last_lmd = vecs[13].lmd;

      // bubble with a taken-branch pattern on the bus: no retire, fields hold
      ex_mem_valid = 1'b0; ex_mem_ir = 32'h00000063; ex_mem_cond = 32'h1;
      @(negedge clk);
      check("bubble_branch", {31'b0, branch_taken}, 32'd0);
      check("bubble_stall",  {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      check("bubble_valid", {31'b0, mem_wb_valid}, 32'd0);
      check("bubble_hold",  mem_wb_lmd, last_lmd);

      // reset during the second REQ cycle aborts; a later ack is ignored
      ex_mem_valid = 1'b1; ex_mem_ir = 32'h00002003; ex_mem_alu = 32'h500;
      ex_mem_b = '0; ex_mem_cond = '0;
      @(posedge clk); #1;
      check("abort_req1", {31'b0, dmem_req}, 32'd1);
      @(posedge clk); #1;
      check("abort_req2", {31'b0, dmem_req}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; ex_mem_valid = 1'b0;
      check("abort_req_low", {31'b0, dmem_req}, 32'd0);
      check("abort_valid",   {31'b0, mem_wb_valid}, 32'd0);
      dmem_ack = 1'b1; dmem_rdata = 32'h5A5A5A5A;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("stray_ack_valid", {31'b0, mem_wb_valid}, 32'd0);
      check("stray_ack_req",   {31'b0, dmem_req}, 32'd0);
      run_instr(32'h00000033, 32'h00001234, 32'h0, 32'h0, 32'h0, 0);
      verify(32'h00000033, 32'h00001234, 1'b0, 1'b0, 4'b0, 32'h0, 0, 0, 32'h0, 1'b0);

      // randomized instructions against the reference model
      ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b1100011;
      for (int n = 0; n < 300; n++) begin
         op  = $urandom_range(0, 3);
         ir  = $urandom;
         ir[6:0] = ops[op];
         tmp = $urandom_range(0, 7);
         ir[14:12] = tmp[2:0];
         alu = $urandom;
         b   = $urandom;
         rd  = $urandom;
         cnd = $urandom;
         w   = $urandom_range(0, 5);
         model(ir, alu, b, rd, w, e_req, e_we, e_be, e_wdata, e_st, e_rc, e_lmd, e_fault);
         run_instr(ir, alu, b, rd, cnd, w);
         verify(ir, alu, e_req, e_we, e_be, e_wdata, e_st, e_rc, e_lmd, e_fault);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            check("rand_bubble_valid", {31'b0, mem_wb_valid}, 32'd0);
            check("rand_bubble_hold",  mem_wb_lmd, e_lmd);
         end
      end

      check("final_req", {31'b0, dmem_req}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
